mem_access_unit: RTL and testbench

MEM-stage front end sitting directly upstream of the word-wide data memory. Receives byte-addressed load/store requests from the EX/MEM register. Translates them into word accesses for the data memory, which has no byte enables, using read-modify-write for SB/SH. Sign- or zero-extends LB/LH/LBU/LHU results before the MEM/WB register.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-wide data memory without byte
// enables. Ports: i_clock/i_reset (async active-low), pipeline request
// (i_valid, i_mem_read, i_mem_write, i_size, i_unsigned, i_byte_address,
// i_store_data), pipeline responses (o_stall, o_load_valid, o_load_data,
// o_misaligned), memory side (o_mem_*, i_mem_read_data).
// Optional macro MISALIGN_TRAP_EN: trap misaligned requests instead of
// truncating the offset.
module mem_access_unit #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_BYTE_ADDR = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  input  logic [NB_BYTE_ADDR-1:0] i_byte_address,
  input  logic [NB_DATA-1:0]      i_store_data,
  output logic                    o_stall,
  output logic                    o_load_valid,
  output logic [NB_DATA-1:0]      o_load_data,
  output logic                    o_misaligned,
  output logic                    o_mem_enable,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic [NB_ADDR-1:0]      o_mem_address,
  output logic [NB_DATA-1:0]      o_mem_write_data,
  input  logic [NB_DATA-1:0]      i_mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RMW_MERGE
  } state_t;

  state_t               state;
  logic [NB_ADDR-1:0]   cap_addr;
  logic [1:0]           cap_off;
  logic                 cap_half;
  logic                 cap_word;
  logic                 cap_uns;
  logic [15:0]          cap_data;

  logic                 is_write;
  logic                 is_read;
  logic                 req;
  logic                 sz_half;
  logic                 sz_word;
  logic [1:0]           raw_off;
  logic [1:0]           off;
  logic                 trap;
  logic                 go;
  logic                 acc_load;
  logic                 acc_sw;
  logic                 acc_rmw;

  logic [NB_DATA-1:0]   shifted;
  logic [NB_DATA-1:0]   load_ext;
  logic [NB_DATA-1:0]   mask;
  logic [NB_DATA-1:0]   rep;
  logic [NB_DATA-1:0]   merged;

  assign is_write = i_mem_write;
  assign is_read  = i_mem_read & ~i_mem_write;
  assign req      = i_valid & (is_write | is_read);
  assign sz_half  = (i_size == 2'b01);
  assign sz_word  = i_size[1];
  assign raw_off  = i_byte_address[1:0];

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis  = (sz_half & raw_off[0]) | (sz_word & |raw_off);
  assign trap = req & mis & (state == IDLE);
  assign off  = raw_off;
`else
  assign trap = 1'b0;
  assign off  = sz_word ? 2'b00 :
                sz_half ? {raw_off[1], 1'b0} : raw_off;
`endif

  assign go       = req & ~trap & (state == IDLE);
  assign acc_load = go & is_read;
  assign acc_sw   = go & is_write & sz_word;
  assign acc_rmw  = go & is_write & ~sz_word;

  // Lane extraction for loads: shift the addressed lane down to bit 0.
  assign shifted = i_mem_read_data >> {cap_off, 3'b000};

  always_comb begin
    load_ext = '0;
    unique case (1'b1)
      cap_word: load_ext = i_mem_read_data;
      cap_half: load_ext = {{16{~cap_uns & shifted[15]}},
                            shifted[15:0]};
      default:  load_ext = {{24{~cap_uns & shifted[7]}},
                            shifted[7:0]};
    endcase
  end

  // Read-modify-write merge of the captured sub-word into the fetched word.
  assign mask   = (cap_half ? NB_DATA'(16'hFFFF) : NB_DATA'(8'hFF))
                  << {cap_off, 3'b000};
  assign rep    = cap_half ? {2{cap_data}} : {4{cap_data[7:0]}};
  assign merged = (i_mem_read_data & ~mask) | (rep & mask);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_off  <= '0;
      cap_half <= 1'b0;
      cap_word <= 1'b0;
      cap_uns  <= 1'b0;
      cap_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc_load) begin
            state    <= LOAD_WAIT;
            cap_off  <= off;
            cap_half <= sz_half;
            cap_word <= sz_word;
            cap_uns  <= i_unsigned;
          end else if (acc_rmw) begin
            state    <= RMW_MERGE;
            cap_addr <= i_byte_address[NB_BYTE_ADDR-1:2];
            cap_off  <= off;
            cap_half <= sz_half;
            cap_word <= 1'b0;
            cap_data <= i_store_data[15:0];
          end
        end
        LOAD_WAIT: state <= IDLE;
        RMW_MERGE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is held, so a pending RMW write
  // never reaches memory.
  always_comb begin
    o_stall          = 1'b0;
    o_load_valid     = 1'b0;
    o_load_data      = '0;
    o_misaligned     = 1'b0;
    o_mem_enable     = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    if (i_reset) begin
      unique case (state)
        IDLE: begin
          o_misaligned = trap;
          o_stall      = acc_load | acc_rmw;
          o_mem_enable = acc_load | acc_sw | acc_rmw;
          o_mem_read   = acc_load | acc_rmw;
          o_mem_write  = acc_sw;
          if (go)
            o_mem_address = i_byte_address[NB_BYTE_ADDR-1:2];
          if (acc_sw)
            o_mem_write_data = i_store_data;
        end
        LOAD_WAIT: begin
          o_load_valid = 1'b1;
          o_load_data  = load_ext;
        end
        RMW_MERGE: begin
          o_mem_enable     = 1'b1;
          o_mem_write      = 1'b1;
          o_mem_address    = cap_addr;
          o_mem_write_data = merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores against a
// word memory model; expected loads and writes checked by a monitor.
module tb_mem_access_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_unsigned = 1'b0;
  logic [6:0]  i_byte_address = '0;
  logic [31:0] i_store_data = '0;
  logic        o_stall;
  logic        o_load_valid;
  logic [31:0] o_load_data;
  logic        o_misaligned;
  logic        o_mem_enable;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [4:0]  o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [31:0] i_mem_read_data = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_load_q [$];
  logic [4:0]  exp_waddr_q [$];
  logic [31:0] exp_wdata_q [$];

  mem_access_unit dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_size           (i_size),
    .i_unsigned       (i_unsigned),
    .i_byte_address   (i_byte_address),
    .i_store_data     (i_store_data),
    .o_stall          (o_stall),
    .o_load_valid     (o_load_valid),
    .o_load_data      (o_load_data),
    .o_misaligned     (o_misaligned),
    .o_mem_enable     (o_mem_enable),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .i_mem_read_data  (i_mem_read_data)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) begin
    if (o_mem_enable && o_mem_write)
      mem[o_mem_address] <= o_mem_write_data;
    if (o_mem_enable && o_mem_read)
      i_mem_read_data <= mem[o_mem_address];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge i_clock) begin
    if (o_load_valid) begin
      if (exp_load_q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        check("load_data", o_load_data, exp_load_q.pop_front());
      end
    end
    if (o_mem_enable && o_mem_write) begin
      if (exp_wdata_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("write_addr", 32'(o_mem_address),
              32'(exp_waddr_q.pop_front()));
        check("write_data", o_mem_write_data, exp_wdata_q.pop_front());
      end
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [6:0] addr,
                    input logic [31:0] data, input logic exp_stall,
                    input logic exp_mis);
    i_valid        = 1'b1;
    i_mem_read     = rd;
    i_mem_write    = wr;
    i_size         = sz;
    i_unsigned     = uns;
    i_byte_address = addr;
    i_store_data   = data;
    @(negedge i_clock);
    check("stall", 32'(o_stall), 32'(exp_stall));
    check("misaligned", 32'(o_misaligned), 32'(exp_mis));
    if (exp_mis)
      check("trap_no_enable", 32'(o_mem_enable), 32'd0);
    @(posedge i_clock);
    #1;
    if (exp_stall) begin
      @(negedge i_clock);
      check("stall_release", 32'(o_stall), 32'd0);
      check("load_valid_latency", 32'(o_load_valid), 32'(rd & ~wr));
      @(posedge i_clock);
      #1;
    end
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  task automatic sw(input logic [6:0] addr, input logic [31:0] data);
    exp_waddr_q.push_back(addr[6:2]);
    exp_wdata_q.push_back(data);
    op(1'b0, 1'b1, 2'b11, 1'b0, addr, data, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns,
                    input logic [6:0] addr, input logic [31:0] exp);
    exp_load_q.push_back(exp);
    op(1'b1, 1'b0, sz, uns, addr, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic st_sub(input logic [1:0] sz, input logic [6:0] addr,
                        input logic [31:0] data, input logic [31:0] word);
    exp_waddr_q.push_back(addr[6:2]);
    exp_wdata_q.push_back(word);
    op(1'b0, 1'b1, sz, 1'b0, addr, data, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    // Reset held with a live request: every output must stay low.
    i_valid = 1'b1;
    i_mem_read = 1'b1;
    i_size = 2'b11;
    i_byte_address = 7'h08;
    @(negedge i_clock);
    check("reset_outputs",
          32'(|{o_stall, o_load_valid, o_load_data, o_misaligned,
                o_mem_enable, o_mem_read, o_mem_write, o_mem_address,
                o_mem_write_data}), 32'd0);
    i_valid = 1'b0;
    i_mem_read = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(negedge i_clock);
    check("idle_enable", 32'(o_mem_enable), 32'd0);
    @(posedge i_clock);
    #1;

    sw(7'h08, 32'hDEADBEEF);
    ld(2'b11, 1'b0, 7'h08, 32'hDEADBEEF);

    // Read+write together: write wins.
    exp_waddr_q.push_back(5'd2);
    exp_wdata_q.push_back(32'h11223344);
    op(1'b1, 1'b1, 2'b11, 1'b0, 7'h08, 32'h11223344, 1'b0, 1'b0);
    st_sub(2'b00, 7'h09, 32'h000000AA, 32'h1122AA44);
    ld(2'b11, 1'b0, 7'h08, 32'h1122AA44);

    sw(7'h08, 32'h80FF7F01);
    ld(2'b00, 1'b0, 7'h0B, 32'hFFFFFF80);
    ld(2'b00, 1'b1, 7'h0B, 32'h00000080);
    ld(2'b01, 1'b0, 7'h0A, 32'hFFFF80FF);
    ld(2'b01, 1'b1, 7'h0A, 32'h000080FF);
    ld(2'b00, 1'b0, 7'h08, 32'h00000001);
    ld(2'b01, 1'b0, 7'h08, 32'h00007F01);
    ld(2'b10, 1'b0, 7'h08, 32'h80FF7F01);

    sw(7'h0C, 32'hAAAAAAAA);
    st_sub(2'b01, 7'h0E, 32'hFFFF1234, 32'h1234AAAA);
    ld(2'b11, 1'b0, 7'h0C, 32'h1234AAAA);
    st_sub(2'b00, 7'h0C, 32'h00000055, 32'h1234AA55);
    ld(2'b11, 1'b0, 7'h0C, 32'h1234AA55);

    sw(7'h04, 32'h89AB8123);
`ifdef MISALIGN_TRAP_EN
    op(1'b1, 1'b0, 2'b01, 1'b0, 7'h05, 32'd0, 1'b0, 1'b1);
    op(1'b0, 1'b1, 2'b11, 1'b0, 7'h06, 32'h0BADF00D, 1'b0, 1'b1);
    ld(2'b11, 1'b0, 7'h04, 32'h89AB8123);
`else
    ld(2'b01, 1'b0, 7'h05, 32'hFFFF8123);
    ld(2'b01, 1'b0, 7'h07, 32'hFFFF89AB);
    exp_waddr_q.push_back(5'd1);
    exp_wdata_q.push_back(32'h0BADF00D);
    op(1'b0, 1'b1, 2'b11, 1'b0, 7'h06, 32'h0BADF00D, 1'b0, 1'b0);
    ld(2'b11, 1'b0, 7'h04, 32'h0BADF00D);
`endif

    // Reset during RMW_MERGE drops the pending write.
    sw(7'h10, 32'h55667788);
    i_valid = 1'b1;
    i_mem_write = 1'b1;
    i_size = 2'b00;
    i_byte_address = 7'h10;
    i_store_data = 32'h000000CC;
    @(negedge i_clock);
    check("rmw_stall", 32'(o_stall), 32'd1);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    #1;
    check("rst_in_rmw_outputs",
          32'(|{o_stall, o_load_valid, o_load_data, o_misaligned,
                o_mem_enable, o_mem_read, o_mem_write, o_mem_address,
                o_mem_write_data}), 32'd0);
    i_valid = 1'b0;
    i_mem_write = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    ld(2'b11, 1'b0, 7'h10, 32'h55667788);

    @(negedge i_clock);
    check("load_q_empty", 32'(exp_load_q.size()), 32'd0);
    check("write_q_empty", 32'(exp_wdata_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
